sram_mem_ctrl: RTL and testbench
================================

// Module: sram_mem_ctrl
// PURPOSE
//  Memory-side stage downstream of the LC-3 datapath: accepts one word read or write request
//  (address from MAR, data from MDR) and sequences the async SRAM pins (CE/UB/LB/OE/WE, ADDR, Data).
//  Returns read data with a one-cycle Done pulse that the control unit uses as memory-ready (R).
//  Owns the bidirectional Data bus; it is the only driver on the FPGA side.
// PARAMETERS
//  RD_WAIT  2  cycles CE/OE held low before read data is sampled (>=1)
//  WR_WAIT  2  cycles WE held low during write pulse (>=1)
// PORTS
//  Clk      in     1   system clock; all state changes on rising edge
//  Reset    in     1   asynchronous, active-low reset
//  Req_Rd   in     1   read request, sampled only in IDLE
//  Req_Wr   in     1   write request, sampled only in IDLE
//  Addr_In  in     16  word address (MAR), latched on acceptance
//  Wr_Data  in     16  write data (MDR), latched on acceptance
//  Byte_En  in     2   write byte enables [1]=upper [0]=lower, latched on acceptance
//  Rd_Data  out    16  registered read data, valid from Done cycle until next read completes
//  Busy     out    1   high in every state except IDLE
//  Done     out    1   one-cycle pulse on completion of either access
//  CE,UB,LB,OE,WE out 1 each  SRAM controls, active-low
//  ADDR     out    20  {4'b0, latched Addr_In}
//  Data     inout  16  SRAM data bus; driven only in write states, else 'z
// BEHAVIOUR
//  Reset (Reset=0, async): state IDLE; CE=UB=LB=OE=WE=1; ADDR=0; Rd_Data=0; Busy=0; Done=0;
//   Data released immediately. Reset mid-access aborts it with no Done.
//  States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. Counter cnt sized for max(RD_WAIT,WR_WAIT).
//  IDLE: all controls 1, Data='z. Req_Wr=1 -> latch addr/data/BE, WR_SETUP. Else Req_Rd=1 ->
//   latch addr, RD, cnt=0. Both high: write wins, read dropped (requester must re-issue).
//  RD: CE=OE=UB=LB=0, WE=1. Stay RD_WAIT cycles; on last RD cycle edge Rd_Data<=Data, go DONE.
//  WR_SETUP (1 cycle): CE=0, OE=1, WE=1, UB=~BE[1], LB=~BE[0], Data driven with latched data.
//  WR_PULSE (WR_WAIT cycles): as WR_SETUP plus WE=0.
//  WR_HOLD (1 cycle): WE=1, CE/UB/LB still asserted, Data still driven (hold time).
//  DONE (1 cycle): Done=1, controls all 1, Data='z, Busy=1; then IDLE.
//  Latency (edge of acceptance = cycle 0): read Done in cycle RD_WAIT+1 (default 3);
//   write Done in cycle WR_WAIT+3 (default 5). Next request accepted earliest cycle after Done.
//  Requests while Busy are ignored (not queued). Byte_En=2'b00 write: full sequence runs,
//   UB=LB=1 throughout so no SRAM byte changes, Done still pulses.
//  Data never driven while OE=0 (no bus contention); ADDR and latched fields stable for whole access.
//  Rd_Data unchanged by writes.
// TESTING
//  Reset low mid-WR_PULSE -> same cycle WE=CE=1, Data='z, Busy=0; no Done after release.
//  Req_Rd, Addr_In=16'h0031, SRAM model returns 16'h1234 -> OE=CE=0 cycles 1-2, Done cycle 3, Rd_Data=16'h1234.
//  Req_Wr, Addr_In=16'h0040, Wr_Data=16'hBEEF, BE=2'b11 -> WE low cycles 2-3, Done cycle 5; read-back=16'hBEEF.
//  Write 16'hAA55 BE=2'b01 over 16'h1234 -> UB=1, LB=0 in WE pulse; read-back 16'h1255.
//  Req_Rd=Req_Wr=1 in IDLE -> write sequence only; second Req_Rd during Busy ignored, exactly one Done.
//  Back-to-back: Req_Rd held high -> accepts in cycle after each Done; Done period = RD_WAIT+2 cycles.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: sequences one async SRAM word read or write per request and
// returns registered read data with a one-cycle Done pulse.
module sram_mem_ctrl #(
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req_Rd,
   input  logic        Req_Wr,
   input  logic [15:0] Addr_In,
   input  logic [15:0] Wr_Data,
   input  logic [1:0]  Byte_En,
   output logic [15:0] Rd_Data,
   output logic        Busy,
   output logic        Done,
   output logic        CE,
   output logic        UB,
   output logic        LB,
   output logic        OE,
   output logic        WE,
   output logic [19:0] ADDR,
   inout  wire  [15:0] Data
);
   localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CW = $clog2(MAXW + 1);
   localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
   localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);

   typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [1:0]    be_q, be_d;
   logic [15:0]   rd_data_q, rd_data_d;
   logic          rd_s, wr_s;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Write takes priority when both requests arrive together; the read is dropped.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rd_data_d = rd_data_q;
      case (state_q)
         IDLE: begin
            if (Req_Wr) begin
               addr_d  = Addr_In;
               wdata_d = Wr_Data;
               be_d    = Byte_En;
               state_d = WR_SETUP;
            end else if (Req_Rd) begin
               addr_d  = Addr_In;
               cnt_d   = '0;
               state_d = RD;
            end
         end
         RD: begin
            if (cnt_q == RD_LAST) begin
               rd_data_d = Data;
               state_d   = DONE;
            end else cnt_d = cnt_q + 1'b1;
         end
         WR_SETUP: begin
            cnt_d   = '0;
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (cnt_q == WR_LAST) state_d = WR_HOLD;
            else cnt_d = cnt_q + 1'b1;
         end
         WR_HOLD: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   assign rd_s    = (state_q == RD);
   assign wr_s    = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
   assign CE      = ~(rd_s | wr_s);
   assign OE      = ~rd_s;
   assign WE      = ~(state_q == WR_PULSE);
   assign UB      = ~(rd_s | (wr_s & be_q[1]));
   assign LB      = ~(rd_s | (wr_s & be_q[0]));
   assign Busy    = (state_q != IDLE);
   assign Done    = (state_q == DONE);
   assign ADDR    = {4'b0, addr_q};
   assign Rd_Data = rd_data_q;
   assign Data    = wr_s ? wdata_q : 16'hzzzz;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: vector table of reads/writes against a small SRAM model,
// plus hand sequences for request collision, back-to-back reads and mid-write reset.
module tb_sram_mem_ctrl;
   localparam int RD_WAIT = 2;
   localparam int WR_WAIT = 2;
   localparam int RD_LAT = RD_WAIT + 1;
   localparam int WR_LAT = WR_WAIT + 3;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Req_Rd, Req_Wr;
   logic [15:0] Addr_In, Wr_Data;
   logic [1:0]  Byte_En;
   logic [15:0] Rd_Data;
   logic        Busy, Done, CE, UB, LB, OE, WE;
   logic [19:0] ADDR;
   wire  [15:0] data_bus;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] sb_q[$];
   logic [15:0] mem [0:255];

   sram_mem_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
      .Clk(Clk), .Reset(Reset), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr),
      .Addr_In(Addr_In), .Wr_Data(Wr_Data), .Byte_En(Byte_En),
      .Rd_Data(Rd_Data), .Busy(Busy), .Done(Done),
      .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .ADDR(ADDR), .Data(data_bus)
   );

   always #5 Clk = ~Clk;

   assign data_bus = (!CE && !OE && WE) ? mem[ADDR[7:0]] : 16'hzzzz;

   always @(posedge Clk) begin
      if (!CE && !WE) begin
         if (!UB) mem[ADDR[7:0]][15:8] <= data_bus[15:8];
         if (!LB) mem[ADDR[7:0]][7:0] <= data_bus[7:0];
      end
   end

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // {CE,UB,LB,OE,WE,Busy,Done} expected c cycles after the acceptance edge
   function automatic logic [6:0] exp_ctrl(input bit wr, input logic [1:0] be, input int c);
      int lat;
      lat = wr ? WR_LAT : RD_LAT;
      if (c > lat) return 7'b1111100;
      if (c == lat) return 7'b1111111;
      if (!wr) return 7'b0000110;
      if (c == 1 || c == WR_WAIT + 2) return {1'b0, ~be[1], ~be[0], 1'b1, 1'b1, 1'b1, 1'b0};
      return {1'b0, ~be[1], ~be[0], 1'b1, 1'b0, 1'b1, 1'b0};
   endfunction

   task automatic run_vec(input vec_t v);
      int lat;
      lat = v.wr ? WR_LAT : RD_LAT;
      Req_Wr  = v.wr;
      Req_Rd  = !v.wr;
      Addr_In = {8'h00, v.addr};
      Wr_Data = v.wdata;
      Byte_En = v.be;
      sb_q.push_back(v.exp_rd);
      for (int c = 1; c <= lat; c++) begin
         tick();
         Req_Wr = 1'b0;
         Req_Rd = 1'b0;
         chk($sformatf("ctrl a%h c%0d", v.addr, c), {CE, UB, LB, OE, WE, Busy, Done}, exp_ctrl(v.wr, v.be, c));
         if (c < lat) chk("addr", ADDR, {12'h000, v.addr});
         if (v.wr && c < lat) chk("wdata_bus", data_bus, v.wdata);
         if (Done) begin
            if (sb_q.size() == 0) chk("sb_empty", 1, 0);
            else chk($sformatf("rd_data a%h", v.addr), Rd_Data, sb_q.pop_front());
         end
      end
      tick();
      chk("idle_after", {Busy, Done}, 2'b00);
   endtask

   initial begin
      int dones, first, last;
      vecs[0] = '{1'b1, 8'h31, 16'h1234, 2'b11, 16'h0000};
      vecs[1] = '{1'b0, 8'h31, 16'h0000, 2'b00, 16'h1234};
      vecs[2] = '{1'b1, 8'h40, 16'hBEEF, 2'b11, 16'h1234};
      vecs[3] = '{1'b0, 8'h40, 16'h0000, 2'b00, 16'hBEEF};
      vecs[4] = '{1'b1, 8'h31, 16'hAA55, 2'b01, 16'hBEEF};
      vecs[5] = '{1'b0, 8'h31, 16'h0000, 2'b00, 16'h1255};
      vecs[6] = '{1'b1, 8'h31, 16'hFFFF, 2'b00, 16'h1255};
      vecs[7] = '{1'b0, 8'h31, 16'h0000, 2'b00, 16'h1255};
      vecs[8] = '{1'b1, 8'h31, 16'h9900, 2'b10, 16'h1255};
      vecs[9] = '{1'b0, 8'h31, 16'h0000, 2'b00, 16'h9955};
      Reset = 1'b0;
      Req_Rd = 1'b0;
      Req_Wr = 1'b0;
      Addr_In = '0;
      Wr_Data = '0;
      Byte_En = '0;
      #2;
      chk("reset_ctrl", {CE, UB, LB, OE, WE, Busy, Done}, 7'b1111100);
      chk("reset_addr", ADDR, 20'h0);
      chk("reset_rd_data", Rd_Data, 16'h0);
      Reset = 1'b1;
      tick();
      foreach (vecs[i]) run_vec(vecs[i]);

      // Simultaneous read and write: only the write runs; a read during Busy is ignored.
      Req_Rd = 1'b1;
      Req_Wr = 1'b1;
      Addr_In = 16'h0050;
      Wr_Data = 16'h5A5A;
      Byte_En = 2'b11;
      dones = 0;
      first = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         Req_Wr = 1'b0;
         Req_Rd = (c == 2);
         Addr_In = (c == 2) ? 16'h0031 : 16'h0050;
         if (c == 2) chk("collide_is_write", {WE, OE}, 2'b01);
         if (Done) begin
            dones++;
            if (first == 0) first = c;
         end
      end
      chk("collide_done_count", dones, 1);
      chk("collide_done_cycle", first, WR_LAT);
      chk("collide_rd_data_kept", Rd_Data, 16'h9955);
      run_vec('{1'b0, 8'h50, 16'h0000, 2'b00, 16'h5A5A});

      // Back-to-back reads with Req_Rd held high.
      Req_Rd = 1'b1;
      Addr_In = 16'h0040;
      dones = 0;
      first = 0;
      last = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (Done) begin
            if (dones == 0) first = c;
            else chk($sformatf("b2b_period %0d", dones), c - last, RD_WAIT + 2);
            last = c;
            dones++;
            chk("b2b_rd_data", Rd_Data, 16'hBEEF);
         end
      end
      Req_Rd = 1'b0;
      chk("b2b_first", first, RD_LAT);
      chk("b2b_count", dones, 5);
      for (int c = 0; c < 6; c++) tick();
      chk("b2b_idle", Busy, 1'b0);

      // Reset asserted during the write pulse aborts the access.
      Req_Wr = 1'b1;
      Addr_In = 16'h0060;
      Wr_Data = 16'h1111;
      Byte_En = 2'b11;
      tick();
      Req_Wr = 1'b0;
      tick();
      chk("pre_abort_we", WE, 1'b0);
      Reset = 1'b0;
      #1;
      chk("abort_ctrl", {CE, WE, Busy, Done}, 4'b1100);
      chk("abort_rd_data", Rd_Data, 16'h0);
      #2;
      Reset = 1'b1;
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (Done) dones++;
      end
      chk("abort_no_done", dones, 0);
      chk("abort_idle", {CE, UB, LB, OE, WE, Busy}, 6'b111111 ^ 6'b000001);
      chk("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
